ps2_key_decoder: RTL and testbench

- Parametrised next-generation PS/2 keyboard receiver.
- Deserialises PS/2 device frames and checks start, odd parity and stop bits.
- Folds E0 (extended) and F0 (break) prefixes into single key events, buffers them in a configurable FIFO, and presents them on a valid/ready interface.
- Sits behind the keyboard UIBI slave; the bus wrapper pops events and reads the sticky status flags.

---
 rtl/ps2_key_decoder.sv | 218 +++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: deserialises device frames, folds E0/F0 prefixes
// into single key events and buffers them in a first-word-fall-through FIFO.
// Ports:
//   clk, rst          system clock, asynchronous active-low reset
//   ps2_clk, ps2_data raw PS/2 pad inputs
//   evt_valid/ready   event handshake; evt_data = {ext, brk, code[7:0]}
//   evt_count         number of buffered events
//   overflow          sticky: event dropped on a full FIFO
//   frame_err         sticky: bad start/parity/stop or frame timeout
//   err_clr           clears both sticky flags
module ps2_key_decoder #(
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned SYNC_STAGES    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [9:0]                    evt_data,
  output logic [$clog2(FIFO_DEPTH):0]   evt_count,
  output logic                          overflow,
  output logic                          frame_err,
  input  logic                          err_clr
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] CODE_E0 = 8'hE0;
  localparam logic [7:0] CODE_F0 = 8'hF0;

  typedef enum logic [1:0] {ST_IDLE, ST_E0, ST_F0, ST_E0F0} state_e;

  // Synchronisers, reset to the idle-high bus level
  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic                   clk_prev_q;
  logic                   sample_c, bit_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign sample_c = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
  assign bit_c    = dat_sync_q[SYNC_STAGES-1];

  // Frame deserialiser and inactivity timeout
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shift_q, shift_d;      // {parity, data[7:0], start} once full
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          byte_valid_q, byte_valid_d;
  logic [7:0]    byte_q, byte_d;
  logic          frame_bad_c, timeout_c;

  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    to_cnt_d     = to_cnt_q;
    byte_valid_d = 1'b0;
    byte_d       = byte_q;
    frame_bad_c  = 1'b0;
    timeout_c    = 1'b0;
    if (sample_c) begin
      to_cnt_d = '0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = 4'd0;
        if (!shift_q[0] && (^shift_q[9:1]) && bit_c) begin
          byte_valid_d = 1'b1;
          byte_d       = shift_q[8:1];
        end else begin
          frame_bad_c = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        shift_d   = {bit_c, shift_q[9:1]};
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        timeout_c = 1'b1;
        bit_cnt_d = 4'd0;
        to_cnt_d  = '0;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  // Prefix-folding decoder
  state_e     state_q, state_d;
  logic       emit_c;
  logic [9:0] emit_data_c;

  always_comb begin
    state_d     = state_q;
    emit_c      = 1'b0;
    emit_data_c = '0;
    if (frame_bad_c || timeout_c) begin
      state_d = ST_IDLE;
    end else if (byte_valid_q) begin
      unique case (state_q)
        ST_IDLE: begin
          if (byte_q == CODE_E0)      state_d = ST_E0;
          else if (byte_q == CODE_F0) state_d = ST_F0;
          else begin
            emit_c      = 1'b1;
            emit_data_c = {2'b00, byte_q};
          end
        end
        ST_E0: begin
          if (byte_q == CODE_F0)      state_d = ST_E0F0;
          else if (byte_q != CODE_E0) begin
            emit_c      = 1'b1;
            emit_data_c = {2'b10, byte_q};
            state_d     = ST_IDLE;
          end
        end
        ST_F0: begin
          if (byte_q != CODE_E0 && byte_q != CODE_F0) begin
            emit_c      = 1'b1;
            emit_data_c = {2'b01, byte_q};
            state_d     = ST_IDLE;
          end
        end
        ST_E0F0: begin
          if (byte_q != CODE_E0 && byte_q != CODE_F0) begin
            emit_c      = 1'b1;
            emit_data_c = {2'b11, byte_q};
            state_d     = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Event FIFO with registered head, count and sticky flags
  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d, cnt_q, cnt_d;
  logic [9:0]    head_q, head_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d, ferr_q, ferr_d;
  logic          pop_c, full_c, push_c, drop_c;

  always_comb begin
    pop_c   = valid_q & evt_ready;
    full_c  = (cnt_q == PW'(FIFO_DEPTH));
    push_c  = emit_c & (~full_c | pop_c);
    drop_c  = emit_c & full_c & ~pop_c;
    wr_d    = wr_q + PW'(push_c);
    rd_d    = rd_q + PW'(pop_c);
    cnt_d   = cnt_q + PW'(push_c) - PW'(pop_c);
    valid_d = (cnt_d != '0);
    // The entry being written this cycle may itself become the new head
    if (cnt_d == '0)
      head_d = '0;
    else if (push_c && (wr_q[AW-1:0] == rd_d[AW-1:0]))
      head_d = emit_data_c;
    else
      head_d = mem_q[rd_d[AW-1:0]];
    ovf_d  = (ovf_q & ~err_clr) | drop_c;
    ferr_d = (ferr_q & ~err_clr) | frame_bad_c | timeout_c;
  end

  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_q[AW-1:0]] <= emit_data_c;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      to_cnt_q     <= '0;
      byte_valid_q <= 1'b0;
      byte_q       <= '0;
      state_q      <= ST_IDLE;
      wr_q         <= '0;
      rd_q         <= '0;
      cnt_q        <= '0;
      head_q       <= '0;
      valid_q      <= 1'b0;
      ovf_q        <= 1'b0;
      ferr_q       <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      to_cnt_q     <= to_cnt_d;
      byte_valid_q <= byte_valid_d;
      byte_q       <= byte_d;
      state_q      <= state_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      cnt_q        <= cnt_d;
      head_q       <= head_d;
      valid_q      <= valid_d;
      ovf_q        <= ovf_d;
      ferr_q       <= ferr_d;
    end
  end

  assign evt_valid = valid_q;
  assign evt_data  = head_q;
  assign evt_count = cnt_q;
  assign overflow  = ovf_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios followed by a
// randomized key stream compared against a prefix-flag event model.
module tb_ps2_key_decoder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned SYNC  = 3;
  localparam int unsigned TMO   = 200;
  localparam int unsigned HALF  = 10;

  logic       clk = 1'b0;
  logic       rst, ps2_clk, ps2_data, evt_ready, err_clr;
  logic       evt_valid, overflow, frame_err;
  logic [9:0] evt_data;
  logic [2:0] evt_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending prefix flags plus a bounded event queue
  logic [9:0] mq[$];
  logic       m_ext = 1'b0;
  logic       m_brk = 1'b0;
  logic       m_ovf = 1'b0;

  always #5 clk = ~clk;

  ps2_key_decoder #(
    .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .evt_count(evt_count), .overflow(overflow), .frame_err(frame_err),
    .err_clr(err_clr)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One device bit; mode selects an action placed while ps2_clk is low
  // 0 none, 1 event latency check, 2 err_clr on the error edge, 3 pop on the write edge
  task automatic ps2_bit(input logic b, input int mode);
    ps2_data = b;
    tick(HALF);
    ps2_clk = 1'b0;
    case (mode)
      1: begin
        tick(SYNC + 1);
        check("latency_early", 32'(evt_valid), 32'd0);
        tick(1);
        check("latency_on", 32'(evt_valid), 32'd1);
        tick(HALF - SYNC - 2);
      end
      2: begin
        tick(SYNC);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("err_beats_clr", 32'(frame_err), 32'd1);
        tick(HALF - SYNC - 1);
      end
      3: begin
        tick(SYNC + 1);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        tick(HALF - SYNC - 2);
      end
      default: tick(HALF);
    endcase
    ps2_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic perr, input logic serr, input int mode);
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 0);
    ps2_bit((~^b) ^ perr, 0);
    ps2_bit(~serr, mode);
    ps2_data = 1'b1;
    tick(HALF);
  endtask

  task automatic pop_expect(input string tag, input logic [9:0] exp);
    check({tag, "_valid"}, 32'(evt_valid), 32'd1);
    check({tag, "_data"}, 32'(evt_data), 32'(exp));
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) begin
      if (!m_brk) m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (mq.size() < DEPTH) mq.push_back({m_ext, m_brk, b});
      else m_ovf = 1'b1;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] b;
    int         k;
    rst = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; evt_ready = 1'b0; err_clr = 1'b0;

    // Reset held with bus activity
    for (int i = 0; i < 6; i++) begin
      ps2_data = 1'($urandom_range(0, 1));
      tick(3);
      ps2_clk = ~ps2_clk;
    end
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    tick(2);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_data", 32'(evt_data), 32'd0);
    check("rst_count", 32'(evt_count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    rst = 1'b1;
    tick(4);

    // First frame with exact latency from the stop-bit edge
    send_byte(8'h1C, 1'b0, 1'b0, 1);
    check("first_count", 32'(evt_count), 32'd1);
    pop_expect("first", 10'h01C);
    check("empty_count", 32'(evt_count), 32'd0);
    check("empty_data", 32'(evt_data), 32'd0);
    check("empty_valid", 32'(evt_valid), 32'd0);

    // Break and extended sequences
    send_byte(8'hF0, 1'b0, 1'b0, 0); send_byte(8'h1C, 1'b0, 1'b0, 0);
    send_byte(8'hE0, 1'b0, 1'b0, 0); send_byte(8'h75, 1'b0, 1'b0, 0);
    send_byte(8'hE0, 1'b0, 1'b0, 0); send_byte(8'hF0, 1'b0, 1'b0, 0);
    send_byte(8'h75, 1'b0, 1'b0, 0);
    check("seq_count", 32'(evt_count), 32'd3);
    pop_expect("brk", 10'h11C);
    pop_expect("ext", 10'h275);
    pop_expect("extbrk", 10'h375);
    check("seq_drained", 32'(evt_count), 32'd0);

    // Frame errors
    send_byte(8'h1C, 1'b1, 1'b0, 0);
    check("par_ferr", 32'(frame_err), 32'd1);
    check("par_noevt", 32'(evt_count), 32'd0);
    clear_errs();
    check("clr_ferr", 32'(frame_err), 32'd0);
    send_byte(8'h1C, 1'b0, 1'b1, 0);
    check("stop_ferr", 32'(frame_err), 32'd1);
    check("stop_noevt", 32'(evt_count), 32'd0);
    send_byte(8'h2B, 1'b1, 1'b0, 2);
    clear_errs();
    check("clr_ferr2", 32'(frame_err), 32'd0);
    // Bad frame discards a pending break prefix
    send_byte(8'hF0, 1'b0, 1'b0, 0);
    send_byte(8'h55, 1'b1, 1'b0, 0);
    send_byte(8'h1C, 1'b0, 1'b0, 0);
    pop_expect("prefix_flush", 10'h01C);
    clear_errs();

    // Idle never times out; a partial frame does
    tick(2 * TMO);
    check("idle_no_tmo", 32'(frame_err), 32'd0);
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1, 0);
    ps2_data = 1'b1;
    tick(TMO / 2);
    check("tmo_early", 32'(frame_err), 32'd0);
    tick(TMO);
    check("tmo_ferr", 32'(frame_err), 32'd1);
    check("tmo_noevt", 32'(evt_count), 32'd0);
    clear_errs();
    send_byte(8'h2A, 1'b0, 1'b0, 0);
    check("tmo_recover_count", 32'(evt_count), 32'd1);
    pop_expect("tmo_recover", 10'h02A);
    check("tmo_recover_ferr", 32'(frame_err), 32'd0);

    // Overflow
    for (int i = 0; i < 5; i++) send_byte(8'(8'h11 + i), 1'b0, 1'b0, 0);
    check("ovf_count", 32'(evt_count), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) pop_expect("ovf_drain", 10'(10'h011 + i));
    check("ovf_empty", 32'(evt_valid), 32'd0);
    clear_errs();
    check("ovf_clr", 32'(overflow), 32'd0);

    // Full FIFO with a pop on the write edge
    for (int i = 0; i < 4; i++) send_byte(8'(8'h21 + i), 1'b0, 1'b0, 0);
    send_byte(8'h25, 1'b0, 1'b0, 3);
    check("fullpop_ovf", 32'(overflow), 32'd0);
    check("fullpop_count", 32'(evt_count), 32'd4);
    for (int i = 0; i < 4; i++) pop_expect("fullpop_drain", 10'(10'h022 + i));
    // Same-edge push and pop when not full
    send_byte(8'h31, 1'b0, 1'b0, 0);
    send_byte(8'h32, 1'b0, 1'b0, 3);
    check("pushpop_count", 32'(evt_count), 32'd1);
    pop_expect("pushpop", 10'h032);

    // Reset mid-frame with an event buffered
    send_byte(8'h44, 1'b0, 1'b0, 0);
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 5; i++) ps2_bit(1'b1, 0);
    rst = 1'b0;
    tick(2);
    check("midrst_count", 32'(evt_count), 32'd0);
    rst = 1'b1;
    ps2_data = 1'b1;
    tick(TMO + 50);
    check("midrst_noevt", 32'(evt_valid), 32'd0);
    check("midrst_ferr", 32'(frame_err), 32'd0);
    send_byte(8'h33, 1'b0, 1'b0, 0);
    pop_expect("midrst_recover", 10'h033);

    // Randomized key stream against the model
    for (int it = 0; it < 40; it++) begin
      k = int'($urandom_range(0, 11));
      if (k < 2) b = 8'hE0;
      else if (k < 4) b = 8'hF0;
      else b = 8'($urandom_range(0, 255));
      if (k == 11) begin
        send_byte(b, 1'b1, 1'b0, 0);
        m_ext = 1'b0;
        m_brk = 1'b0;
        check("rnd_ferr", 32'(frame_err), 32'd1);
        clear_errs();
      end else begin
        send_byte(b, 1'b0, 1'b0, 0);
        model_byte(b);
      end
      check("rnd_count", 32'(evt_count), 32'(mq.size()));
      check("rnd_ovf", 32'(overflow), 32'(m_ovf));
      if (m_ovf) begin
        clear_errs();
        m_ovf = 1'b0;
      end
      k = int'($urandom_range(0, mq.size()));
      for (int p = 0; p < k; p++) pop_expect("rnd_pop", mq.pop_front());
    end
    while (mq.size() > 0) pop_expect("rnd_final", mq.pop_front());
    check("rnd_final_empty", 32'(evt_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
